filter_load_controller: RTL and testbench

FILTER_LOAD_CONTROLLER -- requirements
Module: filter_load_controller

---
 rtl/filter_load_controller.sv | 172 +++++++++++++++++
 tb/tb_filter_load_controller.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/filter_load_controller.sv
// Streams N*N-word filters and then bias words from memory into the filter buffer.
// One read outstanding at a time: a filter takes 2*N*N+1 cycles and a bias 3 cycles at 1-cycle memory latency.
module filter_load_controller #(
  parameter int N  = 5,
  parameter int DW = 16,
  parameter int AW = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [AW-1:0]     base_addr,
  input  logic [15:0]       num_filters,
  input  logic [7:0]        num_bias,
  output logic              busy,
  output logic              done,
  output logic              mem_rd,
  output logic [AW-1:0]     mem_addr,
  input  logic [DW-1:0]     mem_data,
  input  logic              mem_valid,
  output logic              FB_write,
  output logic              FB_bias_or_filter,
  output logic [15:0]       FB_index_filter,
  output logic [15:0]       FB_index_bias,
  output logic [N*N*DW-1:0] FB_filter,
  output logic [DW-1:0]     FB_bias_word
);

  localparam int NN = N * N;
  localparam int KW = (NN > 1) ? $clog2(NN + 1) : 1;
  localparam logic [KW-1:0] K_LAST = KW'(NN - 1);

  typedef enum logic [2:0] {IDLE, FETCH_F, WRITE_F, FETCH_B, WRITE_B, DONE} state_t;

  state_t        state, state_nx;
  logic [15:0]   nf_q, f_q;
  logic [7:0]    nb_q, b_q, nb_clamp;
  logic [KW-1:0] k_q;
  logic          pend_q;
  logic [AW-1:0] ptr_q, rd_addr;
  logic          rsp, issue;

  assign nb_clamp = (num_bias > 8'd120) ? 8'd120 : num_bias;
  // Data only counts when it answers our own outstanding read.
  assign rsp      = pend_q & mem_valid;
  // Filters and biases are contiguous, so one running pointer covers every address.
  assign rd_addr  = (state == IDLE) ? base_addr : ptr_q;

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign FB_write = (state == WRITE_F) || (state == WRITE_B);

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    issue    = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (num_filters != 16'd0) begin
            state_nx = FETCH_F;
            issue    = 1'b1;
          end else if (nb_clamp != 8'd0) begin
            state_nx = FETCH_B;
            issue    = 1'b1;
          end else begin
            state_nx = DONE;
          end
        end
      end
      FETCH_F: begin
        if (rsp) begin
          if (k_q == K_LAST) state_nx = WRITE_F;
          else               issue    = 1'b1;
        end
      end
      WRITE_F: begin
        if (17'(f_q) + 17'd1 < 17'(nf_q)) begin
          state_nx = FETCH_F;
          issue    = 1'b1;
        end else if (nb_q != 8'd0) begin
          state_nx = FETCH_B;
          issue    = 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
      FETCH_B: begin
        if (rsp) state_nx = WRITE_B;
      end
      WRITE_B: begin
        if (b_q + 8'd1 < nb_q) begin
          state_nx = FETCH_B;
          issue    = 1'b1;
        end else begin
          state_nx = DONE;
        end
      end
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_rd            <= 1'b0;
      mem_addr          <= '0;
      ptr_q             <= '0;
      pend_q            <= 1'b0;
      nf_q              <= '0;
      nb_q              <= '0;
      f_q               <= '0;
      k_q               <= '0;
      b_q               <= '0;
      FB_bias_or_filter <= 1'b1;
      FB_index_filter   <= '0;
      FB_index_bias     <= '0;
      FB_filter         <= '0;
      FB_bias_word      <= '0;
    end else begin
      mem_rd <= issue;
      if (issue) begin
        mem_addr <= rd_addr;
        ptr_q    <= rd_addr + AW'(1);
      end
      if (issue)    pend_q <= 1'b1;
      else if (rsp) pend_q <= 1'b0;

      case (state)
        IDLE: begin
          if (start) begin
            nf_q <= num_filters;
            nb_q <= nb_clamp;
            f_q  <= '0;
            k_q  <= '0;
            b_q  <= '0;
          end
        end
        FETCH_F: begin
          if (rsp) begin
            for (int i = 0; i < NN; i++) begin
              if (k_q == KW'(i)) FB_filter[i*DW +: DW] <= mem_data;
            end
            k_q <= k_q + KW'(1);
            // Index and type are set up so they are stable during the WRITE_F cycle.
            if (k_q == K_LAST) begin
              FB_index_filter   <= f_q;
              FB_bias_or_filter <= 1'b1;
            end
          end
        end
        WRITE_F: begin
          f_q <= f_q + 16'd1;
          k_q <= '0;
        end
        FETCH_B: begin
          if (rsp) begin
            FB_bias_word      <= mem_data;
            FB_index_bias     <= {8'd0, b_q};
            FB_bias_or_filter <= 1'b0;
          end
        end
        WRITE_B: b_q <= b_q + 8'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_filter_load_controller.sv
// Directed bench for filter_load_controller: memory responder with configurable latency,
// scoreboard queue of expected filter-buffer writes filled at start and drained on FB_write.
module tb_filter_load_controller;

  localparam int N  = 5;
  localparam int DW = 16;
  localparam int AW = 16;
  localparam int NN = N * N;
  localparam int FW = N * N * DW;

  typedef struct packed {
    logic          isf;
    logic [15:0]   idx;
    logic [FW-1:0] filt;
    logic [DW-1:0] bias;
  } wr_t;

  logic              clk;
  logic              reset;
  logic              start;
  logic [AW-1:0]     base_addr;
  logic [15:0]       num_filters;
  logic [7:0]        num_bias;
  logic              busy;
  logic              done;
  logic              mem_rd;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_data;
  logic              mem_valid;
  logic              FB_write;
  logic              FB_bias_or_filter;
  logic [15:0]       FB_index_filter;
  logic [15:0]       FB_index_bias;
  logic [FW-1:0]     FB_filter;
  logic [DW-1:0]     FB_bias_word;

  filter_load_controller #(.N(N), .DW(DW), .AW(AW)) dut (
    .clk               (clk),
    .reset             (reset),
    .start             (start),
    .base_addr         (base_addr),
    .num_filters       (num_filters),
    .num_bias          (num_bias),
    .busy              (busy),
    .done              (done),
    .mem_rd            (mem_rd),
    .mem_addr          (mem_addr),
    .mem_data          (mem_data),
    .mem_valid         (mem_valid),
    .FB_write          (FB_write),
    .FB_bias_or_filter (FB_bias_or_filter),
    .FB_index_filter   (FB_index_filter),
    .FB_index_bias     (FB_index_bias),
    .FB_filter         (FB_filter),
    .FB_bias_word      (FB_bias_word)
  );

  int checks = 0;
  int errors = 0;

  int          dmode = 0;
  int          lat_rand = 0;
  int          lat_fix = 1;
  int          cyc = 0;
  int          done_cnt = 0, done_cyc = 0, done_base = 0;
  int          wr_cnt = 0, wr_cyc = 0, wr_base = 0;
  int          rd_count = 0, rd_base = 0;
  int          start_cyc = 0;
  logic        pend = 1'b0;
  int          lat_cnt = 0;
  logic [15:0] pend_addr = '0;
  logic [15:0] addr_log[$];
  wr_t         exp_q[$];
  wr_t         e;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [15:0] dfun(input logic [15:0] a);
    if (dmode == 0) return a & 16'h00FF;
    return (a * 16'd7) ^ 16'hA5C3;
  endfunction

  task automatic chk(input string tag, input logic [FW-1:0] obs, input logic [FW-1:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Memory: answers each read after lat cycles with dfun(addr); flags overlapping reads.
  initial begin
    mem_valid = 1'b0;
    mem_data  = '0;
    forever begin
      @(posedge clk); #1;
      mem_valid = 1'b0;
      if (pend) begin
        lat_cnt--;
        if (lat_cnt == 0) begin
          mem_valid = 1'b1;
          mem_data  = dfun(pend_addr);
          pend      = 1'b0;
        end
      end
      if (mem_rd) begin
        rd_count++;
        addr_log.push_back(mem_addr);
        chk("single_outstanding", FW'(pend), FW'(0));
        pend      = 1'b1;
        pend_addr = mem_addr;
        lat_cnt   = (lat_rand != 0) ? int'($urandom_range(1, 4)) : lat_fix;
      end
    end
  end

  // Scoreboard drain on every filter-buffer write.
  initial begin
    forever begin
      @(posedge clk); #1;
      cyc++;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
      if (FB_write) begin
        wr_cnt++;
        wr_cyc = cyc;
        checks++;
        assert (exp_q.size() != 0) else begin
          errors++;
          $error("FAIL unexpected_write: observed=write expected=none idx_f=%0d idx_b=%0d",
                 FB_index_filter, FB_index_bias);
        end
        if (exp_q.size() != 0) begin
          e = exp_q.pop_front();
          chk("fb_bias_or_filter", FW'(FB_bias_or_filter), FW'(e.isf));
          if (e.isf) begin
            chk("fb_index_filter", FW'(FB_index_filter), FW'(e.idx));
            chk("fb_filter", FB_filter, e.filt);
          end else begin
            chk("fb_index_bias", FW'(FB_index_bias), FW'(e.idx));
            chk("fb_bias_word", FW'(FB_bias_word), FW'(e.bias));
          end
        end
      end
    end
  end

  task automatic start_load(input logic [15:0] base, input logic [15:0] nf, input logic [7:0] nb);
    int nbe;
    wr_t w;
    logic [FW-1:0] fv;
    logic [15:0] a;
    nbe = (nb > 8'd120) ? 120 : int'(nb);
    for (int f = 0; f < int'(nf); f++) begin
      fv = '0;
      for (int k = 0; k < NN; k++) begin
        a = base + 16'(f * NN + k);
        fv[k*DW +: DW] = dfun(a);
      end
      w.isf = 1'b1; w.idx = 16'(f); w.filt = fv; w.bias = '0;
      exp_q.push_back(w);
    end
    for (int b = 0; b < nbe; b++) begin
      a = base + 16'(int'(nf) * NN + b);
      w.isf = 1'b0; w.idx = 16'(b); w.filt = '0; w.bias = dfun(a);
      exp_q.push_back(w);
    end
    addr_log.delete();
    rd_base   = rd_count;
    done_base = done_cnt;
    wr_base   = wr_cnt;
    @(negedge clk);
    base_addr   = base;
    num_filters = nf;
    num_bias    = nb;
    start       = 1'b1;
    start_cyc   = cyc;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget, input string tag);
    int n;
    n = 0;
    while (done_cnt == done_base && n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    assert (done_cnt != done_base) else begin
      errors++;
      $error("FAIL %s_timeout: observed=no done expected=done within %0d cycles", tag, budget);
    end
    repeat (2) @(negedge clk);
    chk({tag, "_queue_drained"}, FW'(exp_q.size()), FW'(0));
  endtask

  int bad;
  int n;
  int rd_at_reset;

  initial begin
    reset = 1'b1; start = 1'b0; base_addr = '0; num_filters = '0; num_bias = '0;
    repeat (3) @(negedge clk);

    chk("rst_busy", FW'(busy), FW'(0));
    chk("rst_done", FW'(done), FW'(0));
    chk("rst_mem_rd", FW'(mem_rd), FW'(0));
    chk("rst_mem_addr", FW'(mem_addr), FW'(0));
    chk("rst_fb_write", FW'(FB_write), FW'(0));
    chk("rst_fb_bias_or_filter", FW'(FB_bias_or_filter), FW'(1));
    chk("rst_fb_filter", FB_filter, FW'(0));
    reset = 1'b0;
    @(negedge clk);

    // One filter, data = addr & 0xFF, latency 1.
    dmode = 0; lat_rand = 0; lat_fix = 1;
    start_load(16'h0100, 16'd1, 8'd0);
    wait_done(200, "one_filter");
    chk("one_filter_reads", FW'(addr_log.size()), FW'(25));
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 16'h0100 + 16'(i)) bad++;
    chk("one_filter_addr_mismatches", FW'(bad), FW'(0));
    chk("one_filter_write_cycle", FW'(wr_cyc - start_cyc), FW'(51));
    chk("one_filter_done_cycle", FW'(done_cyc - start_cyc), FW'(52));
    chk("one_filter_write_count", FW'(wr_cnt - wr_base), FW'(1));

    // Three filters then two biases from base 0.
    dmode = 1;
    start_load(16'h0000, 16'd3, 8'd2);
    wait_done(400, "three_two");
    chk("three_two_reads", FW'(addr_log.size()), FW'(77));
    chk("three_two_bias_addr0", FW'(addr_log[75]), FW'(75));
    chk("three_two_bias_addr1", FW'(addr_log[76]), FW'(76));
    chk("three_two_write_count", FW'(wr_cnt - wr_base), FW'(5));

    // Nothing to load.
    start_load(16'h0300, 16'd0, 8'd0);
    wait_done(20, "empty");
    chk("empty_done_cycle", FW'(done_cyc - start_cyc), FW'(1));
    chk("empty_no_reads", FW'(rd_count - rd_base), FW'(0));

    // Address wrap at the top of memory.
    start_load(16'hFFF0, 16'd1, 8'd0);
    wait_done(200, "wrap");
    bad = 0;
    for (int i = 0; i < addr_log.size(); i++) if (addr_log[i] !== 16'hFFF0 + 16'(i)) bad++;
    chk("wrap_addr_mismatches", FW'(bad), FW'(0));
    chk("wrap_last_addr", FW'(addr_log[24]), FW'(16'h0008));

    // Bias count above 120 is clamped; 3 cycles per bias.
    start_load(16'h0200, 16'd0, 8'd200);
    wait_done(1000, "clamp");
    chk("clamp_write_count", FW'(wr_cnt - wr_base), FW'(120));
    chk("clamp_last_addr", FW'(addr_log[addr_log.size()-1]), FW'(16'h0200 + 16'd119));
    chk("clamp_done_cycle", FW'(done_cyc - start_cyc), FW'(361));

    // Random latency, 300 filters plus a few biases.
    lat_rand = 1;
    start_load(16'h1234, 16'd300, 8'd4);
    wait_done(60000, "random");
    chk("random_write_count", FW'(wr_cnt - wr_base), FW'(304));

    // Reset while a read of filter 2 is outstanding.
    lat_rand = 0; lat_fix = 3;
    start_load(16'h0000, 16'd3, 8'd0);
    n = 0;
    while (!((rd_count - rd_base) >= 55 && pend) && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk("midload_reached", FW'(pend), FW'(1));
    chk("midload_writes_before_reset", FW'(wr_cnt - wr_base), FW'(2));
    reset = 1'b1;
    exp_q.delete();
    @(negedge clk);
    reset = 1'b0;
    rd_at_reset = rd_count;
    chk("midrst_busy", FW'(busy), FW'(0));
    chk("midrst_mem_rd", FW'(mem_rd), FW'(0));
    chk("midrst_mem_addr", FW'(mem_addr), FW'(0));
    chk("midrst_fb_write", FW'(FB_write), FW'(0));
    chk("midrst_fb_index_filter", FW'(FB_index_filter), FW'(0));
    chk("midrst_fb_filter", FB_filter, FW'(0));
    chk("midrst_fb_bias_or_filter", FW'(FB_bias_or_filter), FW'(1));
    repeat (8) @(negedge clk);
    chk("late_valid_filter", FB_filter, FW'(0));
    chk("late_valid_no_write", FW'(wr_cnt - wr_base), FW'(2));
    chk("late_valid_no_reads", FW'(rd_count - rd_at_reset), FW'(0));
    chk("late_valid_idle", FW'(busy), FW'(0));
    start_load(16'h0040, 16'd1, 8'd0);
    wait_done(400, "reload");
    chk("reload_first_addr", FW'(addr_log[0]), FW'(16'h0040));
    chk("reload_write_count", FW'(wr_cnt - wr_base), FW'(1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
